// File: rtl/controle_venda_pkg.sv
// Shared types for the drink vending controller: FSM states, display codes,
// internal event codes, credit width and the bill-code-to-value mapping.
package controle_venda_pkg;

    localparam int CREDITO_W = 5;

    typedef logic [CREDITO_W-1:0] credito_t;

    typedef enum logic [2:0] {
        IDLE,
        CREDITO,
        INVALIDA,
        ERRO,
        LIBERA,
        TROCO
    } estado_t;

    typedef enum logic [2:0] {
        SEL_IDLE     = 3'd0,
        SEL_CREDITO  = 3'd1,
        SEL_LIBERA   = 3'd2,
        SEL_TROCO    = 3'd3,
        SEL_ESTOQUE  = 3'd4,
        SEL_INVALIDA = 3'd5
    } select_t;

    // Decision taken while waiting for the customer (IDLE/CREDITO)
    typedef enum logic [2:0] {
        EV_NADA,
        EV_CEDULA_OK,
        EV_CEDULA_INV,
        EV_ERRO,
        EV_LIBERA,
        EV_TROCO
    } evento_t;

    // A value of zero marks an unknown bill code
    function automatic credito_t valor_cedula(input logic [2:0] cod);
        case (cod)
            3'd1:    return credito_t'(1);
            3'd2:    return credito_t'(2);
            3'd3:    return credito_t'(5);
            3'd4:    return credito_t'(10);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/temporizador_hold.sv
// Down-counter shared by every held message state: loads HOLD-1 on entry and
// flags zero on the last cycle of the hold.
module temporizador_hold #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [CW-1:0] contagem;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            contagem <= '0;
        end else if (load) begin
            contagem <= CW'(HOLD - 1);
        end else if (contagem != '0) begin
            contagem <= contagem - CW'(1);
        end
    end

    assign zero = (contagem == '0);

endmodule

// File: rtl/controle_venda.sv
// Vending machine controller: credit accumulation, purchase, error messages.
// Optional change return (TROCO state) is enabled by defining TROCO_EN.
module controle_venda
    import controle_venda_pkg::*;
#(
    parameter int PRECO0 = 3,
    parameter int PRECO1 = 4,
    parameter int PRECO2 = 5,
    parameter int HOLD   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cedula_valid,
    input  logic [2:0]           cedula_cod,
    input  logic [1:0]           bebida_sel,
    input  logic                 confirma,
    input  logic                 cancela,
    input  logic [2:0]           sensores,
    output logic [2:0]           select,
    output logic [CREDITO_W-1:0] soma,
    output logic [1:0]           bebida,
    output logic                 cedulaINV,
    output logic                 valoramais,
    output logic                 libera,
    output logic [CREDITO_W-1:0] troco
);

`ifdef TROCO_EN
    localparam bit TROCO_ATIVO = 1'b1;
`else
    localparam bit TROCO_ATIVO = 1'b0;
`endif

    estado_t          estado;
    evento_t          evento;
    credito_t         preco;
    credito_t         valor;
    logic             estoque_ok;
    logic [CREDITO_W:0] soma_estendida;
    logic             load;
    logic             zero;
    logic             sai_para_troco;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        preco      = '0;
        estoque_ok = 1'b0;
        case (bebida_sel)
            2'd0: begin preco = credito_t'(PRECO0); estoque_ok = sensores[0]; end
            2'd1: begin preco = credito_t'(PRECO1); estoque_ok = sensores[1]; end
            2'd2: begin preco = credito_t'(PRECO2); estoque_ok = sensores[2]; end
            default: ;
        endcase
    end

    assign valor          = valor_cedula(cedula_cod);
    assign soma_estendida = {1'b0, soma} + {1'b0, valor};

    always_comb begin
        evento = EV_NADA;
        if (estado == IDLE || estado == CREDITO) begin
            if (TROCO_ATIVO && cancela) begin
                if (soma != '0) evento = EV_TROCO;
            end else if (confirma) begin
                if (!estoque_ok)        evento = EV_ERRO;
                else if (soma >= preco) evento = EV_LIBERA;
            end else if (cedula_valid) begin
                // The carry bit of the widened sum flags a credit above 31
                if (valor == '0 || soma_estendida[CREDITO_W]) evento = EV_CEDULA_INV;
                else                                          evento = EV_CEDULA_OK;
            end
        end
    end

    assign sai_para_troco = TROCO_ATIVO && (estado == LIBERA) && zero && (soma != '0);
    assign load = (evento inside {EV_CEDULA_INV, EV_ERRO, EV_LIBERA, EV_TROCO}) || sai_para_troco;

    temporizador_hold #(.HOLD(HOLD)) u_temporizador (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .zero  (zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado     <= IDLE;
            select     <= SEL_IDLE;
            soma       <= '0;
            bebida     <= '0;
            cedulaINV  <= 1'b0;
            valoramais <= 1'b0;
            libera     <= 1'b0;
            troco      <= '0;
        end else begin
            libera <= 1'b0;
            case (estado)
                IDLE, CREDITO: begin
                    case (evento)
                        EV_CEDULA_OK: begin
                            soma   <= soma_estendida[CREDITO_W-1:0];
                            estado <= CREDITO;
                            select <= SEL_CREDITO;
                        end
                        EV_CEDULA_INV: begin
                            estado    <= INVALIDA;
                            select    <= SEL_INVALIDA;
                            cedulaINV <= 1'b1;
                        end
                        EV_ERRO: begin
                            estado <= ERRO;
                            select <= SEL_ESTOQUE;
                        end
                        EV_LIBERA: begin
                            estado     <= LIBERA;
                            select     <= SEL_LIBERA;
                            libera     <= 1'b1;
                            bebida     <= bebida_sel;
                            soma       <= soma - preco;
                            valoramais <= (soma != preco);
                        end
                        EV_TROCO: begin
                            estado <= TROCO;
                            select <= SEL_TROCO;
                            troco  <= soma;
                            soma   <= '0;
                        end
                        default: ;
                    endcase
                end
                INVALIDA, ERRO: begin
                    if (zero) begin
                        cedulaINV <= 1'b0;
                        estado    <= (soma == '0) ? IDLE : CREDITO;
                        select    <= (soma == '0) ? SEL_IDLE : SEL_CREDITO;
                    end
                end
                LIBERA: begin
                    if (zero) begin
                        valoramais <= 1'b0;
                        if (sai_para_troco) begin
                            estado <= TROCO;
                            select <= SEL_TROCO;
                            troco  <= soma;
                            soma   <= '0;
                        end else begin
                            estado <= (soma == '0) ? IDLE : CREDITO;
                            select <= (soma == '0) ? SEL_IDLE : SEL_CREDITO;
                        end
                    end
                end
                TROCO: begin
                    if (zero) begin
                        troco  <= '0;
                        estado <= IDLE;
                        select <= SEL_IDLE;
                    end
                end
                default: begin
                    estado <= IDLE;
                    select <= SEL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_venda.sv
// Self-checking bench for controle_venda: directed scenarios followed by random
// transactions predicted by a transaction-level credit model.
module tb_controle_venda;

    localparam int HOLD = 4;
    localparam int P0 = 3;
    localparam int P1 = 4;
    localparam int P2 = 5;

`ifdef TROCO_EN
    localparam bit TEM_TROCO = 1'b1;
`else
    localparam bit TEM_TROCO = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] sel;
        logic [4:0] soma;
        logic [1:0] beb;
        logic       inv;
        logic       vm;
        logic       lib;
        logic [4:0] troco;
    } saida_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cedula_valid;
    logic [2:0] cedula_cod;
    logic [1:0] bebida_sel;
    logic       confirma;
    logic       cancela;
    logic [2:0] sensores;
    logic [2:0] select;
    logic [4:0] soma;
    logic [1:0] bebida;
    logic       cedulaINV;
    logic       valoramais;
    logic       libera;
    logic [4:0] troco;

    int n_checks = 0;
    int n_errors = 0;

    // Model: customer credit and the last drink handed out
    int credito = 0;
    int beb     = 0;

    controle_venda #(.PRECO0(P0), .PRECO1(P1), .PRECO2(P2), .HOLD(HOLD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cedula_valid (cedula_valid),
        .cedula_cod   (cedula_cod),
        .bebida_sel   (bebida_sel),
        .confirma     (confirma),
        .cancela      (cancela),
        .sensores     (sensores),
        .select       (select),
        .soma         (soma),
        .bebida       (bebida),
        .cedulaINV    (cedulaINV),
        .valoramais   (valoramais),
        .libera       (libera),
        .troco        (troco)
    );

    always #5 clk = ~clk;

    function automatic int valor_de(input bit [2:0] c);
        case (c)
            3'd1:    return 1;
            3'd2:    return 2;
            3'd3:    return 5;
            3'd4:    return 10;
            default: return 0;
        endcase
    endfunction

    function automatic int preco_de(input bit [1:0] s);
        case (s)
            2'd0:    return P0;
            2'd1:    return P1;
            2'd2:    return P2;
            default: return 0;
        endcase
    endfunction

    function automatic saida_t mk(input int sel, input int sm, input int bb,
                                  input bit inv, input bit vm, input bit lib, input int tr);
        saida_t s;
        s.sel = 3'(sel); s.soma = 5'(sm); s.beb = 2'(bb);
        s.inv = inv; s.vm = vm; s.lib = lib; s.troco = 5'(tr);
        return s;
    endfunction

    function automatic saida_t ocioso();
        return mk((credito > 0) ? 1 : 0, credito, beb, 1'b0, 1'b0, 1'b0, 0);
    endfunction

    task automatic check(input string tag, input saida_t exp);
        saida_t obs;
        obs = {select, soma, bebida, cedulaINV, valoramais, libera, troco};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed sel=%0d soma=%0d beb=%0d inv=%0b vm=%0b lib=%0b troco=%0d, expected sel=%0d soma=%0d beb=%0d inv=%0b vm=%0b lib=%0b troco=%0d",
                   tag, obs.sel, obs.soma, obs.beb, obs.inv, obs.vm, obs.lib, obs.troco,
                   exp.sel, exp.soma, exp.beb, exp.inv, exp.vm, exp.lib, exp.troco);
        end
    endtask

    task automatic passo();
        @(posedge clk);
        #1;
    endtask

    task automatic limpa_strobes();
        cedula_valid = 1'b0;
        confirma     = 1'b0;
        cancela      = 1'b0;
    endtask

    // Random activity on every input while a message is held; it must be ignored
    task automatic ruido();
        cedula_valid = 1'($urandom_range(0, 1));
        cedula_cod   = 3'($urandom_range(0, 7));
        bebida_sel   = 2'($urandom_range(0, 3));
        confirma     = 1'($urandom_range(0, 1));
        cancela      = 1'($urandom_range(0, 1));
        sensores     = 3'($urandom_range(0, 7));
    endtask

    task automatic segura(input string tag, input saida_t held, input bit pulso);
        saida_t e;
        for (int k = 1; k <= HOLD; k++) begin
            e = held;
            e.lib = pulso && (k == 1);
            check($sformatf("%s_hold%0d", tag, k), e);
            ruido();
            passo();
        end
        limpa_strobes();
    endtask

    task automatic reset_dut(input string tag);
        limpa_strobes();
        rst_n = 1'b0;
        passo();
        credito = 0;
        beb     = 0;
        check(tag, mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 0));
        rst_n = 1'b1;
    endtask

    // One customer action for one cycle, then the predicted output trace
    task automatic executar(input string tag, input bit cv, input bit [2:0] cod,
                            input bit [1:0] sel, input bit conf, input bit canc,
                            input bit [2:0] sens);
        int valor, preco, resto;
        bit estoque;
        valor   = valor_de(cod);
        preco   = preco_de(sel);
        estoque = (sel != 2'd3) && (((sens >> sel) & 3'd1) != 3'd0);
        cedula_valid = cv; cedula_cod = cod; bebida_sel = sel;
        confirma = conf; cancela = canc; sensores = sens;
        passo();
        limpa_strobes();
        if (TEM_TROCO && canc) begin
            if (credito > 0) begin
                segura({tag, "_troco"}, mk(3, 0, beb, 1'b0, 1'b0, 1'b0, credito), 1'b0);
                credito = 0;
            end
        end else if (conf) begin
            if (!estoque) begin
                segura({tag, "_erro"}, mk(4, credito, beb, 1'b0, 1'b0, 1'b0, 0), 1'b0);
            end else if (credito >= preco) begin
                resto = credito - preco;
                beb   = sel;
                segura({tag, "_libera"}, mk(2, resto, beb, 1'b0, resto > 0, 1'b1, 0), 1'b1);
                if (TEM_TROCO && resto > 0) begin
                    segura({tag, "_troco"}, mk(3, 0, beb, 1'b0, 1'b0, 1'b0, resto), 1'b0);
                    credito = 0;
                end else begin
                    credito = resto;
                end
            end
        end else if (cv) begin
            if (valor == 0 || credito + valor > 31) begin
                segura({tag, "_invalida"}, mk(5, credito, beb, 1'b1, 1'b0, 1'b0, 0), 1'b0);
            end else begin
                credito = credito + valor;
            end
        end
        check({tag, "_fim"}, ocioso());
    endtask

    task automatic cedula(input string tag, input bit [2:0] cod);
        executar(tag, 1'b1, cod, 2'd0, 1'b0, 1'b0, 3'b111);
    endtask

    task automatic compra(input string tag, input bit [1:0] sel, input bit [2:0] sens);
        executar(tag, 1'b0, 3'd0, sel, 1'b1, 1'b0, sens);
    endtask

    initial begin
        rst_n = 1'b0;
        limpa_strobes();
        cedula_cod = '0;
        bebida_sel = '0;
        sensores   = 3'b111;

        // Reset state
        passo();
        reset_dut("reset");

        // Two bills then a purchase of drink 1 with change left over
        cedula("nota5", 3'd3);
        cedula("nota2", 3'd2);
        compra("compra1", 2'd1, 3'b111);

        // Unknown bill code is rejected with credit preserved
        reset_dut("reset2");
        cedula("nota1", 3'd1);
        cedula("cod7", 3'd7);

        // Credit overflow: 30 + 2 exceeds 31
        reset_dut("reset3");
        cedula("dez_a", 3'd4);
        cedula("dez_b", 3'd4);
        cedula("dez_c", 3'd4);
        cedula("overflow", 3'd2);
        cedula("limite31", 3'd1);

        // Out of stock on drink 0 with credit 5
        reset_dut("reset4");
        cedula("nota5b", 3'd3);
        compra("sem_estoque", 2'd0, 3'b110);
        compra("sel_invalida", 2'd3, 3'b111);

        // Insufficient credit is ignored, exact price empties the credit
        reset_dut("reset5");
        cedula("nota2b", 3'd2);
        compra("insuficiente", 2'd0, 3'b111);
        cedula("nota1b", 3'd1);
        compra("exato", 2'd0, 3'b111);

        // Reset on the second LIBERA cycle
        reset_dut("reset6");
        cedula("nota5c", 3'd3);
        bebida_sel = 2'd0; sensores = 3'b111; confirma = 1'b1;
        passo();
        confirma = 1'b0;
        check("rst_lib_c1", mk(2, 2, 0, 1'b0, 1'b1, 1'b1, 0));
        rst_n = 1'b0;
        passo();
        credito = 0;
        beb     = 0;
        check("rst_lib_zero", mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 0));
        rst_n = 1'b1;
        for (int k = 0; k < HOLD + 2; k++) begin
            passo();
            check($sformatf("rst_lib_pos%0d", k), ocioso());
        end

        // Cancel request (refund when enabled, ignored otherwise)
        cedula("nota10", 3'd4);
        executar("cancela", 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b111);

        // Random transactions
        for (int n = 0; n < 250; n++) begin
            int op;
            bit [2:0] sens;
            op   = $urandom_range(0, 9);
            sens = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            if (op < 5)
                cedula($sformatf("rnd%0d_cedula", n), 3'($urandom_range(0, 7)));
            else if (op < 8)
                executar($sformatf("rnd%0d_compra", n), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b1, 1'b0, sens);
            else if (op == 8)
                executar($sformatf("rnd%0d_cancela", n), 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 3'b111);
            else
                executar($sformatf("rnd%0d_misto", n), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sens);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
